// File: rtl/axi_id_order_tracker.sv
// axi_id_order_tracker
// Tracks outstanding AXI transactions per ID together with the routing select
// they were issued with. A new push on an ID that still has outstanding
// transactions under a different select is stalled, so responses on one ID
// can never be reordered across two downstream routes. Pops never backpressure;
// a pop that would drive a counter negative clamps the counter at zero and
// raises a one-cycle error pulse.
module axi_id_order_tracker #(
    parameter int unsigned IdBits        = 3,
    parameter int unsigned MaxTransPerId = 7,
    parameter int unsigned MaxTransTotal = 16,
    parameter int unsigned NumPop        = 2,
    parameter type         select_t      = logic,
    localparam int unsigned NoIds        = 2**IdBits,
    localparam int unsigned CntW         = $clog2(MaxTransPerId + 1),
    localparam int unsigned TotW         = $clog2(MaxTransTotal + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_valid_i,
    output logic                           push_ready_o,
    input  logic [IdBits-1:0]              push_id_i,
    input  select_t                        push_sel_i,
    input  logic [NumPop-1:0]              pop_valid_i,
    input  logic [NumPop-1:0][IdBits-1:0]  pop_id_i,
    input  logic [IdBits-1:0]              lookup_id_i,
    output logic                           lookup_taken_o,
    output select_t                        lookup_sel_o,
    output logic [CntW-1:0]                lookup_cnt_o,
    output logic [TotW-1:0]                total_cnt_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           pop_err_o
);

    // Width able to count every pop port hitting one ID in a single cycle.
    localparam int unsigned PopW = $clog2(NumPop + 1);
    // Width holding cnt + push and the pop count without overflow.
    localparam int unsigned ArW  = ((CntW > PopW) ? CntW : PopW) + 1;
    // Width holding the sum of legal pops across all IDs (at most total + 1).
    localparam int unsigned SumW = TotW + 1;

    logic [CntW-1:0] r_cnt [NoIds];
    select_t         r_sel [NoIds];
    logic [TotW-1:0] r_total;
    logic            r_pop_err;

    logic            w_full;
    logic            w_push_ready;
    logic            w_push_acc;
    logic [NoIds-1:0] w_push_hit;
    logic [NoIds-1:0] w_underflow;
    logic [PopW-1:0] w_pops_hit [NoIds];
    logic [ArW-1:0]  w_avail    [NoIds];
    logic [CntW-1:0] w_cnt_nxt  [NoIds];
    logic [SumW-1:0] w_legal_pops;
    logic [TotW-1:0] w_total_nxt;

    assign w_full     = (r_total == TotW'(MaxTransTotal));
    assign w_push_acc = push_valid_i && w_push_ready;

    // Push admission from registered state only: same-select ordering, per-ID limit, global limit.
    always_comb begin
        w_push_ready = 1'b0;
        if (((r_cnt[push_id_i] == '0) || (r_sel[push_id_i] == push_sel_i)) &&
            (r_cnt[push_id_i] < CntW'(MaxTransPerId)) && !w_full) begin
            w_push_ready = 1'b1;
        end else begin
            w_push_ready = 1'b0;
        end
    end

    // Per-ID net change: count pop hits, clamp underflow at zero, accumulate legal pops.
    always_comb begin
        w_push_hit   = '0;
        w_underflow  = '0;
        w_legal_pops = '0;
        for (int i = 0; i < NoIds; i++) begin
            w_pops_hit[i] = '0;
            w_avail[i]    = '0;
            w_cnt_nxt[i]  = r_cnt[i];
        end
        for (int i = 0; i < NoIds; i++) begin
            w_push_hit[i] = w_push_acc && (push_id_i == IdBits'(i));
            for (int k = 0; k < NumPop; k++) begin
                if (pop_valid_i[k] && (pop_id_i[k] == IdBits'(i))) begin
                    w_pops_hit[i] = w_pops_hit[i] + PopW'(1);
                end else begin
                    w_pops_hit[i] = w_pops_hit[i];
                end
            end
            w_avail[i] = ArW'(r_cnt[i]) + ArW'(w_push_hit[i]);
            if (ArW'(w_pops_hit[i]) > w_avail[i]) begin
                // Excess pops are discarded; only the available ones count as legal.
                w_underflow[i] = 1'b1;
                w_cnt_nxt[i]   = '0;
                w_legal_pops   = w_legal_pops + SumW'(w_avail[i]);
            end else begin
                w_underflow[i] = 1'b0;
                w_cnt_nxt[i]   = CntW'(w_avail[i] - ArW'(w_pops_hit[i]));
                w_legal_pops   = w_legal_pops + SumW'(w_pops_hit[i]);
            end
        end
        w_total_nxt = TotW'(SumW'(r_total) + SumW'(w_push_acc) - w_legal_pops);
    end

    // State registers: per-ID counters and selects, running total, error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NoIds; i++) begin
                r_cnt[i] <= '0;
                r_sel[i] <= '0;
            end
            r_total   <= '0;
            r_pop_err <= 1'b0;
        end else begin
            for (int i = 0; i < NoIds; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                if (w_push_hit[i]) begin
                    r_sel[i] <= push_sel_i;
                end else begin
                    r_sel[i] <= r_sel[i];
                end
            end
            r_total   <= w_total_nxt;
            r_pop_err <= |w_underflow;
        end
    end

    assign push_ready_o   = w_push_ready;
    assign lookup_cnt_o   = r_cnt[lookup_id_i];
    assign lookup_sel_o   = r_sel[lookup_id_i];
    assign lookup_taken_o = (r_cnt[lookup_id_i] != '0);
    assign total_cnt_o    = r_total;
    assign full_o         = w_full;
    assign empty_o        = (r_total == '0);
    assign pop_err_o      = r_pop_err;

endmodule

// File: tb/tb_axi_id_order_tracker.sv
// Directed bench for axi_id_order_tracker with default parameters
// (8 IDs, 7 per ID, 16 total, 2 pop ports, 1-bit select).
module tb_axi_id_order_tracker;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            push_valid;
    logic            push_ready;
    logic [2:0]      push_id;
    logic            push_sel;
    logic [1:0]      pop_valid;
    logic [1:0][2:0] pop_id;
    logic [2:0]      lookup_id;
    logic            lookup_taken;
    logic            lookup_sel;
    logic [2:0]      lookup_cnt;
    logic [4:0]      total_cnt;
    logic            full;
    logic            empty;
    logic            pop_err;

    int n_checks = 0;
    int n_fail   = 0;

    axi_id_order_tracker dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .push_valid_i   (push_valid),
        .push_ready_o   (push_ready),
        .push_id_i      (push_id),
        .push_sel_i     (push_sel),
        .pop_valid_i    (pop_valid),
        .pop_id_i       (pop_id),
        .lookup_id_i    (lookup_id),
        .lookup_taken_o (lookup_taken),
        .lookup_sel_o   (lookup_sel),
        .lookup_cnt_o   (lookup_cnt),
        .total_cnt_o    (total_cnt),
        .full_o         (full),
        .empty_o        (empty),
        .pop_err_o      (pop_err)
    );

    always #5 clk = ~clk;

    // One clock cycle with the given push/pop stimulus; valids drop 1 ns after the edge.
    task automatic step(input logic pv, input logic [2:0] pid, input logic psel,
                        input logic [1:0] popv, input logic [2:0] p0, input logic [2:0] p1);
        push_valid = pv;
        push_id    = pid;
        push_sel   = psel;
        pop_valid  = popv;
        pop_id[0]  = p0;
        pop_id[1]  = p1;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_valid  = 2'b00;
    endtask

    task automatic test_reset();
        push_id = 3'd0; push_sel = 1'b0; lookup_id = 3'd0;
        #1;
        n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", push_ready); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (lookup_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b expected 0", lookup_taken); end
        n_checks++; if (lookup_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b expected 0", lookup_sel); end
        n_checks++; if (lookup_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", lookup_cnt); end
        n_checks++; if (total_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_total: got %0d expected 0", total_cnt); end
        n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL reset_pop_err: got %b expected 0", pop_err); end
    endtask

    task automatic test_lookup();
        for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 1'b1, 2'b00, 3'd0, 3'd0);
        lookup_id = 3'd3;
        #1;
        n_checks++; if (lookup_cnt !== 3'd3) begin n_fail++; $display("FAIL lookup_cnt: got %0d expected 3", lookup_cnt); end
        n_checks++; if (lookup_taken !== 1'b1) begin n_fail++; $display("FAIL lookup_taken: got %b expected 1", lookup_taken); end
        n_checks++; if (lookup_sel !== 1'b1) begin n_fail++; $display("FAIL lookup_sel: got %b expected 1", lookup_sel); end
        n_checks++; if (total_cnt !== 5'd3) begin n_fail++; $display("FAIL lookup_total: got %0d expected 3", total_cnt); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL lookup_empty: got %b expected 0", empty); end
    endtask

    task automatic test_order_stall();
        lookup_id = 3'd3;
        push_id = 3'd3; push_sel = 1'b0; push_valid = 1'b1;
        #1;
        n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready3: got %b expected 0", push_ready); end
        step(1'b1, 3'd3, 1'b0, 2'b01, 3'd3, 3'd0);
        n_checks++; if (lookup_cnt !== 3'd2) begin n_fail++; $display("FAIL stall_cnt2: got %0d expected 2", lookup_cnt); end
        step(1'b1, 3'd3, 1'b0, 2'b01, 3'd3, 3'd0);
        n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready1: got %b expected 0", push_ready); end
        // Last pop with the mismatched push still waiting: no same-cycle credit.
        step(1'b1, 3'd3, 1'b0, 2'b01, 3'd3, 3'd0);
        n_checks++; if (lookup_cnt !== 3'd0) begin n_fail++; $display("FAIL stall_cnt0: got %0d expected 0", lookup_cnt); end
        n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_after: got %b expected 1", push_ready); end
        n_checks++; if (lookup_sel !== 1'b1) begin n_fail++; $display("FAIL stall_sel_kept: got %b expected 1", lookup_sel); end
        n_checks++; if (lookup_taken !== 1'b0) begin n_fail++; $display("FAIL stall_taken: got %b expected 0", lookup_taken); end
        n_checks++; if (total_cnt !== 5'd0) begin n_fail++; $display("FAIL stall_total: got %0d expected 0", total_cnt); end
    endtask

    task automatic test_limits();
        logic err_seen;
        for (int i = 0; i < 7; i++) step(1'b1, 3'd2, 1'b0, 2'b00, 3'd0, 3'd0);
        lookup_id = 3'd2;
        push_id = 3'd2; push_sel = 1'b0;
        #1;
        n_checks++; if (lookup_cnt !== 3'd7) begin n_fail++; $display("FAIL limit_cnt2: got %0d expected 7", lookup_cnt); end
        n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL limit_ready2: got %b expected 0", push_ready); end
        push_id = 3'd5; push_sel = 1'b1;
        #1;
        n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL limit_ready5: got %b expected 1", push_ready); end
        n_checks++; if (total_cnt !== 5'd7) begin n_fail++; $display("FAIL limit_total7: got %0d expected 7", total_cnt); end
        for (int i = 0; i < 7; i++) step(1'b1, 3'd5, 1'b1, 2'b00, 3'd0, 3'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 3'd1, 1'b0, 2'b00, 3'd0, 3'd0);
        n_checks++; if (total_cnt !== 5'd16) begin n_fail++; $display("FAIL full_total: got %0d expected 16", total_cnt); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", full); end
        for (int j = 0; j < 8; j++) begin
            push_id = 3'(j); push_sel = 1'b0;
            #1;
            n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready id %0d: got %b expected 0", j, push_ready); end
        end
        step(1'b1, 3'd0, 1'b0, 2'b00, 3'd0, 3'd0);
        lookup_id = 3'd0;
        #1;
        n_checks++; if (total_cnt !== 5'd16) begin n_fail++; $display("FAIL full_push_total: got %0d expected 16", total_cnt); end
        n_checks++; if (lookup_cnt !== 3'd0) begin n_fail++; $display("FAIL full_push_cnt0: got %0d expected 0", lookup_cnt); end
        err_seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 3'd0, 1'b0, 2'b11, 3'd2, 3'd5);
            if (pop_err) err_seen = 1'b1;
        end
        step(1'b0, 3'd0, 1'b0, 2'b11, 3'd1, 3'd1);
        if (pop_err) err_seen = 1'b1;
        n_checks++; if (total_cnt !== 5'd0) begin n_fail++; $display("FAIL drain_total: got %0d expected 0", total_cnt); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
        n_checks++; if (err_seen !== 1'b0) begin n_fail++; $display("FAIL drain_pop_err: got %b expected 0", err_seen); end
    endtask

    task automatic test_push_pop_same();
        lookup_id = 3'd4;
        step(1'b1, 3'd4, 1'b0, 2'b00, 3'd0, 3'd0);
        n_checks++; if (lookup_cnt !== 3'd1) begin n_fail++; $display("FAIL same_cnt1: got %0d expected 1", lookup_cnt); end
        step(1'b1, 3'd4, 1'b0, 2'b01, 3'd4, 3'd0);
        n_checks++; if (lookup_cnt !== 3'd1) begin n_fail++; $display("FAIL same_net0_cnt: got %0d expected 1", lookup_cnt); end
        n_checks++; if (total_cnt !== 5'd1) begin n_fail++; $display("FAIL same_net0_total: got %0d expected 1", total_cnt); end
        step(1'b1, 3'd4, 1'b0, 2'b11, 3'd4, 3'd4);
        n_checks++; if (lookup_cnt !== 3'd0) begin n_fail++; $display("FAIL same_two_pops_cnt: got %0d expected 0", lookup_cnt); end
        n_checks++; if (total_cnt !== 5'd0) begin n_fail++; $display("FAIL same_two_pops_total: got %0d expected 0", total_cnt); end
        n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL same_two_pops_err: got %b expected 0", pop_err); end
        step(1'b1, 3'd4, 1'b1, 2'b01, 3'd4, 3'd0);
        n_checks++; if (lookup_sel !== 1'b1) begin n_fail++; $display("FAIL same_sel_update: got %b expected 1", lookup_sel); end
        n_checks++; if (lookup_cnt !== 3'd0) begin n_fail++; $display("FAIL same_sel_cnt: got %0d expected 0", lookup_cnt); end
        n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL same_sel_err: got %b expected 0", pop_err); end
    endtask

    task automatic test_underflow();
        lookup_id = 3'd6;
        step(1'b1, 3'd1, 1'b0, 2'b00, 3'd0, 3'd0);
        step(1'b0, 3'd0, 1'b0, 2'b01, 3'd6, 3'd0);
        n_checks++; if (pop_err !== 1'b1) begin n_fail++; $display("FAIL under_err: got %b expected 1", pop_err); end
        n_checks++; if (lookup_cnt !== 3'd0) begin n_fail++; $display("FAIL under_cnt: got %0d expected 0", lookup_cnt); end
        n_checks++; if (total_cnt !== 5'd1) begin n_fail++; $display("FAIL under_total: got %0d expected 1", total_cnt); end
        step(1'b0, 3'd0, 1'b0, 2'b00, 3'd0, 3'd0);
        n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL under_err_pulse: got %b expected 0", pop_err); end
        step(1'b1, 3'd6, 1'b0, 2'b00, 3'd0, 3'd0);
        step(1'b0, 3'd0, 1'b0, 2'b11, 3'd6, 3'd6);
        n_checks++; if (pop_err !== 1'b1) begin n_fail++; $display("FAIL under2_err: got %b expected 1", pop_err); end
        n_checks++; if (lookup_cnt !== 3'd0) begin n_fail++; $display("FAIL under2_cnt: got %0d expected 0", lookup_cnt); end
        n_checks++; if (total_cnt !== 5'd1) begin n_fail++; $display("FAIL under2_total: got %0d expected 1", total_cnt); end
        step(1'b0, 3'd0, 1'b0, 2'b01, 3'd1, 3'd0);
        n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL under2_err_pulse: got %b expected 0", pop_err); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL under_clean_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 1'b0, 2'b00, 3'd0, 3'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 3'd7, 1'b1, 2'b00, 3'd0, 3'd0);
        n_checks++; if (total_cnt !== 5'd5) begin n_fail++; $display("FAIL mid_total5: got %0d expected 5", total_cnt); end
        lookup_id = 3'd7;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (total_cnt !== 5'd0) begin n_fail++; $display("FAIL mid_total0: got %0d expected 0", total_cnt); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b expected 1", empty); end
        n_checks++; if (lookup_cnt !== 3'd0) begin n_fail++; $display("FAIL mid_cnt7: got %0d expected 0", lookup_cnt); end
        n_checks++; if (lookup_sel !== 1'b0) begin n_fail++; $display("FAIL mid_sel7: got %b expected 0", lookup_sel); end
        lookup_id = 3'd0;
        #1;
        n_checks++; if (lookup_taken !== 1'b0) begin n_fail++; $display("FAIL mid_taken0: got %b expected 0", lookup_taken); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'd0, 1'b0, 2'b00, 3'd0, 3'd0);
        n_checks++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL mid_after_err: got %b expected 0", pop_err); end
        n_checks++; if (total_cnt !== 5'd0) begin n_fail++; $display("FAIL mid_after_total: got %0d expected 0", total_cnt); end
    endtask

    initial begin
        push_valid = 1'b0; push_id = 3'd0; push_sel = 1'b0;
        pop_valid = 2'b00; pop_id[0] = 3'd0; pop_id[1] = 3'd0; lookup_id = 3'd0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_lookup();
        test_order_stall();
        test_limits();
        test_push_pop_same();
        test_underflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_id_order_tracker.md
AXI_ID_ORDER_TRACKER -- requirements
Module: axi_id_order_tracker

Interface
REQ-001 SHALL have parameter IdBits, default 3, meaning tracked AXI ID bits; NoIds = 2**IdBits.
REQ-002 SHALL have parameter MaxTransPerId, default 7, meaning maximum outstanding transactions per ID (>=1).
REQ-003 SHALL have parameter MaxTransTotal, default 16, meaning maximum outstanding transactions across all IDs (>=1).
REQ-004 SHALL have parameter NumPop, default 2, meaning number of independent pop (response) ports.
REQ-005 SHALL have parameter type select_t, default logic, meaning routing select stored per ID.
REQ-006 SHALL derive CntW = $clog2(MaxTransPerId+1) and TotW = $clog2(MaxTransTotal+1).
REQ-007 SHALL have clk_i  input  1  single clock, rising edge.
REQ-008 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have push_valid_i  input  1  request to record a new transaction.
REQ-010 SHALL have push_ready_o  output  1  push may be accepted this cycle.
REQ-011 SHALL have push_id_i  input  IdBits  ID of pushed transaction.
REQ-012 SHALL have push_sel_i  input  select_t  select for pushed transaction.
REQ-013 SHALL have pop_valid_i  input  NumPop  per-port completion strobe.
REQ-014 SHALL have pop_id_i  input  NumPop x IdBits  per-port completed ID.
REQ-015 SHALL have lookup_id_i  input  IdBits  ID to query.
REQ-016 SHALL have lookup_taken_o  output  1  queried ID has count > 0.
REQ-017 SHALL have lookup_sel_o  output  select_t  stored select of queried ID.
REQ-018 SHALL have lookup_cnt_o  output  CntW  outstanding count of queried ID.
REQ-019 SHALL have total_cnt_o  output  TotW  registered sum of all outstanding transactions.
REQ-020 SHALL have full_o  output  1  total_cnt_o == MaxTransTotal.
REQ-021 SHALL have empty_o  output  1  total_cnt_o == 0.
REQ-022 SHALL have pop_err_o  output  1  registered one-cycle pulse flagging an illegal pop.

Function
REQ-023 SHALL hold per ID a CntW counter cnt[i] and a select_t register sel[i].
REQ-024 SHALL drive push_ready_o = (cnt[push_id_i]==0 || sel[push_id_i]==push_sel_i) && cnt[push_id_i]<MaxTransPerId && !full_o; ordering stall on select mismatch.
REQ-025 SHALL compute push_ready_o from current registered state only; same-cycle pops grant no lookahead credit.
REQ-026 SHALL accept a push iff push_valid_i && push_ready_o; push_ready_o SHALL NOT depend on push_valid_i.
REQ-027 SHALL on accepted push write sel[push_id_i] <= push_sel_i at next edge; sel of non-pushed IDs unchanged, including when count returns to 0.
REQ-028 SHALL always accept pops (no backpressure); pop port k is valid when pop_valid_i[k]=1.
REQ-029 SHALL update each counter per cycle: cnt[i] <= cnt[i] + push_hit[i] - pops_hit[i], where pops_hit[i] counts ports k with pop_valid_i[k] && pop_id_i[k]==i (0..NumPop).
REQ-030 SHALL on underflow (pops_hit[i] > cnt[i]+push_hit[i]) set cnt[i] to 0 and assert pop_err_o on the next cycle for exactly one cycle.
REQ-031 SHALL treat simultaneous push and pop on the same ID as net-change arithmetic (e.g. push+1 pop: count unchanged, sel updated).
REQ-032 SHALL update total_cnt_o <= total_cnt_o + accepted_push - legal_pops, where legal_pops excludes pops discarded under REQ-030; total_cnt_o SHALL always equal the sum of cnt[i].
REQ-033 SHALL make lookup_taken_o, lookup_sel_o, lookup_cnt_o combinational from registered state, one-cycle visibility after a push/pop.
REQ-034 SHALL never wrap a counter: per-ID count bounded by REQ-024 and REQ-030.

Reset
REQ-035 SHALL on rst_ni low immediately clear all cnt[i], sel[i], total_cnt_o and pop_err_o to 0, independent of clk_i.
REQ-036 SHALL after reset output push_ready_o=1 (given !full), empty_o=1, full_o=0, lookup_taken_o=0, lookup_sel_o='0.
REQ-037 SHALL discard all in-flight state when reset asserts mid-operation; no pop_err_o arises from pops of pre-reset transactions.

Verification
REQ-038 SHALL cover: push id 3 sel 1 three times, then lookup id 3 -> lookup_cnt_o=3, lookup_taken_o=1, lookup_sel_o=1, total_cnt_o=3.
REQ-039 SHALL cover: id 3 outstanding with sel 1, push id 3 sel 0 -> push_ready_o=0 until last pop of id 3, then 1 next cycle.
REQ-040 SHALL cover: push 7 on id 2 -> push_ready_o=0 for id 2 while id 5 push still ready; 16 total pushes -> full_o=1, push_ready_o=0 for all IDs.
REQ-041 SHALL cover: cnt[4]=1, same cycle push id 4 and pop on both ports id 4 -> cnt[4]=0, total decreases by 1, no pop_err_o.
REQ-042 SHALL cover: pop id 6 when cnt[6]=0 -> cnt stays 0, total unchanged, pop_err_o=1 for exactly one cycle.
REQ-043 SHALL cover: assert rst_ni low with total_cnt_o=5 mid-clock -> all counts 0 and empty_o=1 before the next edge.
